// File: rtl/rvh_noc_pkg.sv
// Shared NoC definitions: default flit width, flit type and small sizing helpers.
package rvh_noc_pkg;

  // Default flit payload width used across the router datapath.
  localparam int unsigned NOC_FLIT_W = 64;

  // One flit payload at the default width.
  typedef logic [NOC_FLIT_W-1:0] noc_flit_t;

  // Width of an index over n entries; at least one bit so a single-entry
  // structure still has a legal (constant zero) index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/std_dffr.sv
// Plain D flop bank with asynchronous active-low reset to zero.
module std_dffr #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d every rising edge; clear asynchronously on reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of the order blocks are evaluated in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/std_dffrve.sv
// D flop bank with load enable and asynchronous active-low reset to zero.
module std_dffrve #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d on enabled rising edges; clear asynchronously on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/vc_fifo.sv
// Single virtual-channel flit FIFO. The caller presents only qualified
// push/pop requests (push never hits a full FIFO unless popped the same
// cycle, pop never hits an empty FIFO). Head data is read combinationally
// from storage, so a written flit appears at the head the cycle after the
// write edge with no bypass.
module vc_fifo
  import rvh_noc_pkg::*;
#(
  parameter int DEPTH = 1,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int W     = NOC_FLIT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     dat_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic [W-1:0]     head_dat_o
);

  localparam int PTR_W = idx_w(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic [W-1:0]     mem [DEPTH];

  // Next pointers wrap explicitly so non-power-of-2 depths stay in range;
  // occupancy moves only when exactly one of push/pop happens.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and a latch is never inferred.
  always_comb begin
    wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    count_d  = count_q;
    if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
    else if (!push_i && pop_i) count_d = count_q - CNT_W'(1);
  end

  std_dffrve #(.WIDTH(PTR_W)) u_wr_ptr (
    .clk(clk), .rstn(rstn), .en(push_i), .d(wr_ptr_d), .q(wr_ptr_q)
  );

  std_dffrve #(.WIDTH(PTR_W)) u_rd_ptr (
    .clk(clk), .rstn(rstn), .en(pop_i), .d(rd_ptr_d), .q(rd_ptr_q)
  );

  std_dffr #(.WIDTH(CNT_W)) u_count (
    .clk(clk), .rstn(rstn), .d(count_d), .q(count_q)
  );

  // Flit storage write port.
  // NOTE: storage carries no reset; validity comes solely from the reset
  // occupancy, so clearing the array would only cost area and timing.
  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q] <= dat_i;
  end

  assign head_dat_o = mem[rd_ptr_q];
  assign count_o    = count_q;
  assign full_o     = (count_q == CNT_FULL);
  assign empty_o    = (count_q == '0);

  a_count_le_depth: assert property (
    @(posedge clk) disable iff (!rstn) count_q <= CNT_FULL
  ) else $error("vc_fifo occupancy exceeds depth");

endmodule

// File: rtl/input_port_vc_buffer.sv
// Router input-port buffer: one FIFO per virtual channel, registered credit
// return on every accepted pop, and sticky overflow/underflow flags for
// dropped writes and ignored pops (including out-of-range VC ids).
module input_port_vc_buffer
  import rvh_noc_pkg::*;
#(
  parameter int VC_NUM             = 4,
  parameter int VC_NUM_IDX_W       = VC_NUM > 1 ? $clog2(VC_NUM) : 1,
  parameter int VC_DEPTH           = 1,
  parameter int VC_DEPTH_COUNTER_W = $clog2(VC_DEPTH + 1),
  parameter int FLIT_W             = NOC_FLIT_W
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         flit_vld_i,
  input  logic [VC_NUM_IDX_W-1:0]                      flit_vc_id_i,
  input  logic [FLIT_W-1:0]                            flit_dat_i,
  input  logic                                         pop_vld_i,
  input  logic [VC_NUM_IDX_W-1:0]                      pop_vc_id_i,
  output logic [VC_NUM-1:0]                            vc_head_vld_o,
  output logic [VC_NUM-1:0][FLIT_W-1:0]                vc_head_dat_o,
  output logic [VC_NUM-1:0][VC_DEPTH_COUNTER_W-1:0]    vc_occupancy_o,
  output logic                                         free_vc_credit_vld_o,
  output logic [VC_NUM_IDX_W-1:0]                      free_vc_credit_vc_id_o,
  output logic                                         overflow_err_o,
  output logic                                         underflow_err_o
);

  logic [VC_NUM-1:0] wr_hit, pop_hit;
  logic [VC_NUM-1:0] push_ok, pop_ok;
  logic [VC_NUM-1:0] full, empty;

  logic                    cred_vld_d, cred_vld_q;
  logic [VC_NUM_IDX_W-1:0] cred_id_d, cred_id_q;
  logic                    ovf_d, ovf_q;
  logic                    udf_d, udf_q;

  // Decode requests per VC, qualify them against FIFO state, and derive the
  // credit and sticky error next-state. An out-of-range id matches no VC, so
  // it is neither accepted nor stored, and it trips the matching error flag.
  // A full VC still accepts a write when that same VC is popped this cycle.
  always_comb begin
    wr_hit  = '0;
    pop_hit = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      wr_hit[v]  = flit_vld_i && (flit_vc_id_i == VC_NUM_IDX_W'(v));
      pop_hit[v] = pop_vld_i  && (pop_vc_id_i  == VC_NUM_IDX_W'(v));
    end
    pop_ok     = pop_hit & ~empty;
    push_ok    = wr_hit & (~full | pop_ok);
    cred_vld_d = |pop_ok;
    cred_id_d  = cred_vld_d ? pop_vc_id_i : '0;
    ovf_d      = ovf_q | (flit_vld_i && (push_ok == '0));
    udf_d      = udf_q | (pop_vld_i  && (pop_ok  == '0));
  end

  for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
    vc_fifo #(
      .DEPTH (VC_DEPTH),
      .CNT_W (VC_DEPTH_COUNTER_W),
      .W     (FLIT_W)
    ) u_vc_fifo (
      .clk        (clk),
      .rstn       (rstn),
      .push_i     (push_ok[v]),
      .pop_i      (pop_ok[v]),
      .dat_i      (flit_dat_i),
      .full_o     (full[v]),
      .empty_o    (empty[v]),
      .count_o    (vc_occupancy_o[v]),
      .head_dat_o (vc_head_dat_o[v])
    );
  end

  std_dffr #(.WIDTH(1)) u_cred_vld (
    .clk(clk), .rstn(rstn), .d(cred_vld_d), .q(cred_vld_q)
  );

  std_dffr #(.WIDTH(VC_NUM_IDX_W)) u_cred_id (
    .clk(clk), .rstn(rstn), .d(cred_id_d), .q(cred_id_q)
  );

  std_dffr #(.WIDTH(1)) u_ovf (
    .clk(clk), .rstn(rstn), .d(ovf_d), .q(ovf_q)
  );

  std_dffr #(.WIDTH(1)) u_udf (
    .clk(clk), .rstn(rstn), .d(udf_d), .q(udf_q)
  );

  assign vc_head_vld_o          = ~empty;
  assign free_vc_credit_vld_o   = cred_vld_q;
  assign free_vc_credit_vc_id_o = cred_id_q;
  assign overflow_err_o         = ovf_q;
  assign underflow_err_o        = udf_q;

  a_credit_after_pop: assert property (
    @(posedge clk) disable iff (!rstn) free_vc_credit_vld_o |-> $past(|pop_ok)
  ) else $error("credit returned without an accepted pop");

endmodule

// File: tb/tb_input_port_vc_buffer.sv
// Randomized self-checking bench for input_port_vc_buffer with a
// queue-based reference model of the per-VC buffers, credits and flags.
module tb_input_port_vc_buffer;
  import rvh_noc_pkg::*;

  localparam int VC_NUM   = 4;
  localparam int IDX_W    = 2;
  localparam int VC_DEPTH = 2;
  localparam int CNT_W    = 2;
  localparam int FLIT_W   = 64;

  logic                            clk = 1'b0;
  logic                            rstn;
  logic                            flit_vld_i;
  logic [IDX_W-1:0]                flit_vc_id_i;
  logic [FLIT_W-1:0]               flit_dat_i;
  logic                            pop_vld_i;
  logic [IDX_W-1:0]                pop_vc_id_i;
  logic [VC_NUM-1:0]               vc_head_vld_o;
  logic [VC_NUM-1:0][FLIT_W-1:0]   vc_head_dat_o;
  logic [VC_NUM-1:0][CNT_W-1:0]    vc_occupancy_o;
  logic                            free_vc_credit_vld_o;
  logic [IDX_W-1:0]                free_vc_credit_vc_id_o;
  logic                            overflow_err_o;
  logic                            underflow_err_o;

  input_port_vc_buffer #(
    .VC_NUM   (VC_NUM),
    .VC_DEPTH (VC_DEPTH),
    .FLIT_W   (FLIT_W)
  ) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .flit_vld_i             (flit_vld_i),
    .flit_vc_id_i           (flit_vc_id_i),
    .flit_dat_i             (flit_dat_i),
    .pop_vld_i              (pop_vld_i),
    .pop_vc_id_i            (pop_vc_id_i),
    .vc_head_vld_o          (vc_head_vld_o),
    .vc_head_dat_o          (vc_head_dat_o),
    .vc_occupancy_o         (vc_occupancy_o),
    .free_vc_credit_vld_o   (free_vc_credit_vld_o),
    .free_vc_credit_vc_id_o (free_vc_credit_vc_id_o),
    .overflow_err_o         (overflow_err_o),
    .underflow_err_o        (underflow_err_o)
  );

  always #5 clk = ~clk;

  // Reference model state.
  noc_flit_t      mdl_q [VC_NUM][$];
  bit             exp_cred_vld;
  int             exp_cred_id;
  bit             exp_ovf;
  bit             exp_udf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    for (int v = 0; v < VC_NUM; v++) begin
      check($sformatf("head_vld[%0d]", v), 64'(vc_head_vld_o[v]), 64'(mdl_q[v].size() != 0));
      check($sformatf("occupancy[%0d]", v), 64'(vc_occupancy_o[v]), 64'(mdl_q[v].size()));
      if (mdl_q[v].size() != 0)
        check($sformatf("head_dat[%0d]", v), vc_head_dat_o[v], mdl_q[v][0]);
    end
    check("credit_vld", 64'(free_vc_credit_vld_o), 64'(exp_cred_vld));
    check("credit_id", 64'(free_vc_credit_vc_id_o), 64'(exp_cred_id));
    check("overflow_err", 64'(overflow_err_o), 64'(exp_ovf));
    check("underflow_err", 64'(underflow_err_o), 64'(exp_udf));
  endtask

  // Apply one clock edge of the buffer's rules to the model.
  task automatic model_update(input bit wv, input int wid, input noc_flit_t wd,
                              input bit pv, input int pid);
    bit pop_acc, push_acc;
    pop_acc  = pv && (pid < VC_NUM) && (mdl_q[pid].size() > 0);
    push_acc = wv && (wid < VC_NUM) &&
               ((mdl_q[wid].size() < VC_DEPTH) || (pop_acc && pid == wid));
    exp_cred_vld = pop_acc;
    exp_cred_id  = pop_acc ? pid : 0;
    if (pv && !pop_acc) exp_udf = 1'b1;
    if (wv && !push_acc) exp_ovf = 1'b1;
    if (pop_acc)  void'(mdl_q[pid].pop_front());
    if (push_acc) mdl_q[wid].push_back(wd);
  endtask

  // One cycle: check current outputs, drive inputs, take the edge, update model.
  task automatic step(input bit wv, input int wid, input noc_flit_t wd,
                      input bit pv, input int pid);
    @(negedge clk);
    check_outputs();
    flit_vld_i   = wv;
    flit_vc_id_i = IDX_W'(wid);
    flit_dat_i   = wd;
    pop_vld_i    = pv;
    pop_vc_id_i  = IDX_W'(pid);
    @(posedge clk);
    model_update(wv, wid, wd, pv, pid);
  endtask

  task automatic idle();
    step(1'b0, 0, '0, 1'b0, 0);
  endtask

  // Assert reset asynchronously, check cleared outputs at once, then release.
  task automatic do_reset();
    rstn         = 1'b0;
    flit_vld_i   = 1'b0;
    flit_vc_id_i = '0;
    flit_dat_i   = '0;
    pop_vld_i    = 1'b0;
    pop_vc_id_i  = '0;
    #1;
    check("rst_credit_vld", 64'(free_vc_credit_vld_o), 64'd0);
    check("rst_credit_id", 64'(free_vc_credit_vc_id_o), 64'd0);
    check("rst_overflow", 64'(overflow_err_o), 64'd0);
    check("rst_underflow", 64'(underflow_err_o), 64'd0);
    check("rst_head_vld", 64'(vc_head_vld_o), 64'd0);
    for (int v = 0; v < VC_NUM; v++)
      check($sformatf("rst_occupancy[%0d]", v), 64'(vc_occupancy_o[v]), 64'd0);
    for (int v = 0; v < VC_NUM; v++) mdl_q[v].delete();
    exp_cred_vld = 1'b0;
    exp_cred_id  = 0;
    exp_ovf      = 1'b0;
    exp_udf      = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    do_reset();

    // Back-to-back writes to VC2; 0xA at head, two flits stored.
    step(1'b1, 2, 64'hA, 1'b0, 0);
    #1 check("d_first_write_head_vld", 64'(vc_head_vld_o[2]), 64'd1);
    check("d_first_write_head_dat", vc_head_dat_o[2], 64'hA);
    step(1'b1, 2, 64'hB, 1'b0, 0);
    #1 check("d_two_writes_occ", 64'(vc_occupancy_o[2]), 64'd2);

    // Drain VC2: heads 0xA then 0xB, a credit for VC2 after each pop.
    step(1'b0, 0, '0, 1'b1, 2);
    #1 check("d_pop1_credit_vld", 64'(free_vc_credit_vld_o), 64'd1);
    check("d_pop1_credit_id", 64'(free_vc_credit_vc_id_o), 64'd2);
    check("d_pop1_next_head", vc_head_dat_o[2], 64'hB);
    step(1'b0, 0, '0, 1'b1, 2);
    #1 check("d_pop2_credit_id", 64'(free_vc_credit_vc_id_o), 64'd2);
    check("d_drained_head_vld", 64'(vc_head_vld_o[2]), 64'd0);
    check("d_drained_occ", 64'(vc_occupancy_o[2]), 64'd0);
    idle();

    // VC1 full, simultaneous write 0xC and pop: still full, no error.
    step(1'b1, 1, 64'h11, 1'b0, 0);
    step(1'b1, 1, 64'h12, 1'b0, 0);
    step(1'b1, 1, 64'hC, 1'b1, 1);
    #1 check("d_full_wr_pop_occ", 64'(vc_occupancy_o[1]), 64'd2);
    check("d_full_wr_pop_credit", 64'(free_vc_credit_vc_id_o), 64'd1);
    check("d_full_wr_pop_no_ovf", 64'(overflow_err_o), 64'd0);
    step(1'b0, 0, '0, 1'b1, 1);
    #1 check("d_full_wr_pop_tail", vc_head_dat_o[1], 64'hC);
    step(1'b0, 0, '0, 1'b1, 1);

    // VC0 full, write 0xD without pop: dropped, sticky overflow.
    step(1'b1, 0, 64'h21, 1'b0, 0);
    step(1'b1, 0, 64'h22, 1'b0, 0);
    step(1'b1, 0, 64'hD, 1'b0, 0);
    #1 check("d_drop_ovf", 64'(overflow_err_o), 64'd1);
    check("d_drop_occ", 64'(vc_occupancy_o[0]), 64'd2);
    repeat (3) idle();

    // Pop empty VC3: no credit, sticky underflow, VC0 untouched.
    step(1'b0, 0, '0, 1'b1, 3);
    #1 check("d_empty_pop_udf", 64'(underflow_err_o), 64'd1);
    check("d_empty_pop_no_credit", 64'(free_vc_credit_vld_o), 64'd0);
    check("d_empty_pop_vc0_occ", 64'(vc_occupancy_o[0]), 64'd2);
    idle();

    // Reset while a credit is pending.
    step(1'b0, 0, '0, 1'b1, 0);
    #1 check("d_credit_pending", 64'(free_vc_credit_vld_o), 64'd1);
    do_reset();

    // Randomized traffic against the model, with a reset part-way through.
    for (int i = 0; i < 600; i++) begin
      bit        wv, pv;
      int        wid, pid;
      noc_flit_t wd;
      wv  = ($urandom_range(0, 3) != 0);
      pv  = ($urandom_range(0, 2) != 0);
      wid = $urandom_range(0, VC_NUM - 1);
      pid = $urandom_range(0, VC_NUM - 1);
      wd  = {$urandom, $urandom};
      step(wv, wid, wd, pv, pid);
      if (i == 300) begin
        #1 do_reset();
      end
    end
    @(negedge clk);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_port_vc_buffer.md
INPUT_PORT_VC_BUFFER -- requirements
Module: input_port_vc_buffer

Interface
REQ-001 SHALL have parameter VC_NUM, default 4: number of virtual channels on this input port.
REQ-002 SHALL have parameter VC_NUM_IDX_W, default VC_NUM>1 ? $clog2(VC_NUM) : 1: VC id width.
REQ-003 SHALL have parameter VC_DEPTH, default 1: flit slots per VC; equals upstream credit counter reset value.
REQ-004 SHALL have parameter VC_DEPTH_COUNTER_W, default $clog2(VC_DEPTH+1): occupancy width.
REQ-005 SHALL have parameter FLIT_W, default 64: flit payload width.
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port flit_vld_i  input  1  flit arriving from link.
REQ-009 SHALL have port flit_vc_id_i  input  VC_NUM_IDX_W  target VC of arriving flit.
REQ-010 SHALL have port flit_dat_i  input  FLIT_W  arriving flit payload.
REQ-011 SHALL have port pop_vld_i  input  1  switch traversal consumes one head flit.
REQ-012 SHALL have port pop_vc_id_i  input  VC_NUM_IDX_W  VC being popped.
REQ-013 SHALL have port vc_head_vld_o  output  VC_NUM  per-VC head flit valid (VC non-empty).
REQ-014 SHALL have port vc_head_dat_o  output  VC_NUM x FLIT_W  per-VC head flit payload.
REQ-015 SHALL have port vc_occupancy_o  output  VC_NUM x VC_DEPTH_COUNTER_W  per-VC stored flit count.
REQ-016 SHALL have port free_vc_credit_vld_o  output  1  credit return to upstream output port.
REQ-017 SHALL have port free_vc_credit_vc_id_o  output  VC_NUM_IDX_W  VC whose credit is returned.
REQ-018 SHALL have port overflow_err_o  output  1  sticky: write to full VC was dropped.
REQ-019 SHALL have port underflow_err_o  output  1  sticky: pop of empty VC was ignored.

Function
REQ-020 SHALL store flits per VC in FIFO order, each VC holding at most VC_DEPTH flits.
REQ-021 SHALL make a written flit visible on vc_head_*_o the cycle after the write edge; no same-cycle write-to-head bypass.
REQ-022 SHALL, on pop of non-empty VC, advance that VC's head at the clock edge; next head (or head_vld=0) visible the following cycle.
REQ-023 SHALL, on same-cycle write and pop of same VC, perform both; occupancy unchanged; legal even when VC full.
REQ-024 SHALL, on same-cycle write and pop of different VCs, perform both independently.
REQ-025 SHALL, on write to a full VC without same-cycle pop of that VC, drop the flit, leave state unchanged, set overflow_err_o next cycle.
REQ-026 SHALL, on pop of an empty VC, change no state, return no credit, set underflow_err_o next cycle.
REQ-027 SHALL register credit return: accepted pop at edge N drives free_vc_credit_vld_o=1 and vc_id=pop_vc_id_i during cycle N+1; otherwise free_vc_credit_vld_o=0.
REQ-028 SHALL hold free_vc_credit_vc_id_o at 0 when free_vc_credit_vld_o is 0.
REQ-029 SHALL keep read/write pointers in range 0..VC_DEPTH-1 with explicit wrap to 0 (pointer width max(1,$clog2(VC_DEPTH))), supporting non-power-of-2 VC_DEPTH and VC_DEPTH=1.
REQ-030 SHALL keep vc_occupancy_o equal to stored flits, never exceeding VC_DEPTH.
REQ-031 SHALL ignore out-of-range vc ids (>= VC_NUM) on write and pop, flagging overflow_err_o or underflow_err_o respectively.

Reset
REQ-032 SHALL on rstn low asynchronously clear all pointers and occupancies, vc_head_vld_o=0, free_vc_credit_vld_o=0, free_vc_credit_vc_id_o=0, both error flags=0.
REQ-033 SHALL not reset flit storage; vc_head_dat_o is don't-care while vc_head_vld_o=0.
REQ-034 SHALL discard any in-flight credit return when reset asserts mid-operation; the upstream counter resets to VC_DEPTH concurrently.

Structure
REQ-035 SHALL place the shared flit type and FLIT_W default in rvh_noc_pkg; no new package.
REQ-036 SHALL instantiate one sub-module per VC, named vc_fifo (push, pop, full, empty, count, head data).
REQ-037 SHALL use the codebase std_dffr/std_dffrve flops for all reset state.
REQ-038 SHALL include non-synthesis assertions: occupancy <= VC_DEPTH; no credit without prior accepted pop.

Verification (VC_NUM=4, VC_DEPTH=2, FLIT_W=64)
REQ-039 SHALL cover: write VC2 0xA, 0xB back-to-back -> head_vld[2]=1 with 0xA cycle after first write, occupancy[2]=2.
REQ-040 SHALL cover: pop VC2 twice -> heads 0xA then 0xB; credits vc_id=2 one cycle after each pop; head_vld[2]=0 and occupancy[2]=0 at end.
REQ-041 SHALL cover: VC1 full, same-cycle write 0xC and pop VC1 -> occupancy[1] stays 2, 0xC last, one credit vc_id=1, no error.
REQ-042 SHALL cover: VC0 full, write 0xD without pop -> flit dropped, occupancy[0]=2, overflow_err_o=1 until reset.
REQ-043 SHALL cover: pop empty VC3 -> no credit, underflow_err_o=1, other VCs unaffected.
REQ-044 SHALL cover: assert rstn low while a credit is pending -> free_vc_credit_vld_o=0 immediately, all occupancies 0, error flags 0.
